// File: rtl/timer_pkg.sv
// timer_pkg -- definitions shared by the MM:SS stopwatch core.
//   timer_state_e : control FSM states (IDLE / RUN / PAUSE)
//   BCD_W         : width of one BCD digit
//   BCD_BLANK     : code the downstream seven-segment decoder shows as all segments off
//   *_MAX         : wrap value of each digit in the MM:SS chain
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } timer_state_e;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_ONES_MAX = 9;
  localparam int MIN_TENS_MAX = 5;

endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter -- one decimal digit of the stopwatch chain.
// Counts 0..MAX on inc, wraps to 0 and asserts carry in the same cycle, so
// chained instances ripple combinationally and all digits update on one edge.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear to 0, overrides inc
//   inc        : advance by one this cycle
//   digit      : registered digit value (0..MAX)
//   carry      : inc & (digit == MAX), feeds inc of the next digit
module bcd_digit_counter import timer_pkg::*; #(
  parameter int MAX = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);

  localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MAX);

  logic [BCD_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr)      digit_d = '0;
    else if (inc) digit_d = (digit_q == MAX_V) ? '0 : digit_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit = digit_q;
  assign carry = inc & (digit_q == MAX_V);

endmodule

// File: rtl/timer_bcd_counter.sv
// timer_bcd_counter -- MM:SS stopwatch core (00:00 .. 59:59).
// A prescaler divides clk to a one-per-second tick while RUN; the tick drives
// a four-digit BCD chain. A start/stop/clear FSM (IDLE/RUN/PAUSE) gates it.
//   TICKS_PER_SEC : clk cycles per counted second (>= 2)
//   clk, rst_n    : clock, synchronous active-low reset
//   start_stop    : level, acted on at its rising edge (toggles run/pause)
//   clear         : level, while high forces IDLE and zeroes the count
//   sec_ones/sec_tens/min_ones/min_tens : registered BCD digits
//   running       : high while in RUN
//   rollover      : one-cycle pulse on the 59:59 -> 00:00 wrap
// Build option: define TIMER_BLANK_ZERO_EN to show min_tens as BCD_BLANK
// whenever its value is 0 (leading-zero blanking on the display).
module timer_bcd_counter import timer_pkg::*; #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_stop,
  input  logic             clear,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             running,
  output logic             rollover
);

  localparam int NUM_DIG = 4;
  localparam int PW      = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  timer_state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ss_q;
  logic          arm_q;
  logic          running_q;
  logic          rollover_q;
  logic          ss_rise;
  logic          tick;

  logic [NUM_DIG-1:0]            inc_v;
  logic [NUM_DIG-1:0]            carry_v;
  logic [NUM_DIG-1:0][BCD_W-1:0] dig_v;

  // arm_q stays low after reset until start_stop is seen low, so a button
  // held through reset does not start the timer on release.
  assign ss_rise = start_stop & ~ss_q & arm_q;
  assign tick    = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    unique case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (ss_rise) state_d = ST_RUN;
      end
      ST_RUN: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (ss_rise) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        // prescaler holds, so resume keeps the partial second
        if (ss_rise) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      ss_q       <= 1'b0;
      arm_q      <= 1'b0;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      ss_q       <= start_stop;
      arm_q      <= arm_q | ~start_stop;
      running_q  <= (state_d == ST_RUN);
      // carry out of min_tens only happens on the 59:59 increment
      rollover_q <= carry_v[NUM_DIG-1];
    end
  end

  // clear wins over a tick landing in the same cycle
  assign inc_v[0] = tick & ~clear;

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    localparam int MAX_I = (i == 0) ? SEC_ONES_MAX :
                           (i == 1) ? SEC_TENS_MAX :
                           (i == 2) ? MIN_ONES_MAX : MIN_TENS_MAX;
    bcd_digit_counter #(.MAX(MAX_I)) u_dig (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clear),
      .inc  (inc_v[i]),
      .digit(dig_v[i]),
      .carry(carry_v[i])
    );
    if (i < NUM_DIG - 1) begin : g_chain
      assign inc_v[i+1] = carry_v[i];
    end
  end

  assign sec_ones = dig_v[0];
  assign sec_tens = dig_v[1];
  assign min_ones = dig_v[2];
`ifdef TIMER_BLANK_ZERO_EN
  // decode straight off the digit register: no input path, no extra cycle
  assign min_tens = (dig_v[3] == '0) ? BCD_BLANK : dig_v[3];
`else
  assign min_tens = dig_v[3];
`endif
  assign running  = running_q;
  assign rollover = rollover_q;

endmodule

// File: doc/timer_bcd_counter.md
# timer_bcd_counter

Minutes:seconds stopwatch core for the timer design. It divides the system clock down to a 1 Hz count enable and keeps four BCD digits (MM:SS, 00:00 to 59:59). A start/stop/clear control FSM runs the count. Each digit output drives one `seven_seg_decoder` instance directly, which places this block immediately upstream of the display stage.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per counted second. Must be ≥ 2. Benches use a small value.
- `clk` input 1: single system clock. All logic is on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start_stop` input 1: level input, already synchronised and debounced upstream. The block acts on its rising edge only.
- `clear` input 1: level input, synchronised. Active-high while held.
- `sec_ones` output 4: BCD 0–9.
- `sec_tens` output 4: BCD 0–5.
- `min_ones` output 4: BCD 0–9.
- `min_tens` output 4: BCD 0–5, or the blank code (see Configuration).
- `running` output 1: high while in the RUN state.
- `rollover` output 1: one-cycle pulse on the 59:59 → 00:00 wrap.

## Operation
- The FSM has three states: IDLE, RUN and PAUSE.
- `ss_rise` is asserted when `start_stop` is 1 and its registered copy is 0.
- IDLE:
  - `ss_rise` → RUN, and the prescaler loads 0.
  - All digits hold at 0.
- RUN:
  - The prescaler counts 0 … `TICKS_PER_SEC`-1.
  - At the terminal value the prescaler returns to 0 and the digit chain increments once.
  - `ss_rise` → PAUSE.
- PAUSE:
  - The prescaler and digits hold their values.
  - `ss_rise` → RUN, and the prescaler resumes from its held value without reloading.
- `clear` = 1 in any state:
  - The next state is IDLE and the prescaler and all digits become 0.
  - `clear` overrides `ss_rise` and any tick in the same cycle.
  - The block stays in IDLE while `clear` is held. `ss_rise` events during that time are ignored.
- Digit chain:
  - `sec_ones` wraps 9 → 0 and carries into `sec_tens`.
  - `sec_tens` wraps 5 → 0 and carries into `min_ones`.
  - `min_ones` wraps 9 → 0 and carries into `min_tens`.
  - `min_tens` wraps 5 → 0.
  - All carries ripple within the same cycle.
  - An increment from 59:59 yields 00:00. `rollover` is high for that one cycle and the FSM stays in RUN.
- Digit values never leave their legal BCD range, except the blank code on `min_tens`.

## Timing
- Reset values (on a `clk` edge with `rst_n` = 0):
  - State IDLE, prescaler 0, all digits 0 (`min_tens` = 4'hF if blanking is enabled).
  - `running` = 0, `rollover` = 0, registered copy of `start_stop` = 0.
- Reset takes priority over `clear` and `start_stop`. Reset mid-count discards the current count without producing a `rollover` pulse.
- All outputs are registered. There is no combinational path from input to output.
- `start_stop` response: `running` changes on the same edge that first samples `start_stop` = 1 after a sampled 0.
- Count timing from IDLE: the first increment lands exactly `TICKS_PER_SEC` edges after the edge that entered RUN. Every later increment follows at `TICKS_PER_SEC`-edge intervals.
- Pause/resume: the accumulated sub-second count is preserved. Total RUN cycles, not wall time, sets the count.
- `rollover` is asserted on the same edge that the digits become 00:00. It deasserts on the next edge.
- If `start_stop` is held high across reset, no `ss_rise` occurs until it falls and rises again.

## Configuration
- `TIMER_BLANK_ZERO_EN` not defined: `min_tens` always shows its BCD value, including 0.
- `TIMER_BLANK_ZERO_EN` defined:
  - When the registered `min_tens` value is 0, the `min_tens` output is 4'hF. The downstream decoder maps 4'hF to all segments off.
  - The internal counter still holds 0, and the carry and rollover logic are unchanged.
  - The output stays registered with no added latency.
  - Only `min_tens` is blanked.

## Structure
- Shared package `timer_pkg`:
  - state enum (`ST_IDLE`, `ST_RUN`, `ST_PAUSE`)
  - `BCD_W` = 4
  - `BCD_BLANK` = 4'hF
  - digit limits `SEC_TENS_MAX` = 5 and `MIN_TENS_MAX` = 5
- Sub-module `bcd_digit_counter`:
  - parameter `MAX`; inputs `clk`, `rst_n`, `clr`, `inc`
  - outputs `digit[3:0]` and `carry`; `carry` = `inc` & (`digit` == `MAX`)
  - Instantiated four times, chained by `carry` → `inc`.
- The top level holds the prescaler, edge detect, FSM and optional blanking.

## Test plan
All scenarios use `TICKS_PER_SEC` = 4.
- Reset then idle: hold `rst_n` = 0 for 2 cycles then release, wait 20 cycles → digits 00:00, `running` = 0, `rollover` never 1.
- Start and count: pulse `start_stop` one cycle, run 40 cycles → `running` = 1 from the pulse edge; `sec_ones` reaches 9 at edge 36, `sec_tens`:`sec_ones` = 1:0 at edge 40.
- Pause/resume: run 6 cycles, pause 10, resume, run 2 more → 00:02, same as 8 uninterrupted cycles.
- Rollover: run to 59:59, wait one more tick → 00:00 with `rollover` high for exactly one cycle, `running` still 1.
- Clear priority: assert `clear` and `start_stop` rising on the same cycle at 03:27 → 00:00, state IDLE, `running` = 0.
- Blanking build (`TIMER_BLANK_ZERO_EN` defined): count to 09:59 → `min_tens` = 4'hF; next tick → `min_tens` = 1, `min_ones` = 0.
